block_draw: RTL

- Pixel-rasterising stage directly downstream of the x/y/colour loader in the block-stacker datapath.
- Takes a latched row origin (x, y), colour, erase flag and block count, then emits one VGA-adapter pixel write per cycle to fill a horizontal run of square blocks.
- Signals completion back to the game control FSM.

---
 rtl/stacker_pkg.sv | 19 +
 rtl/raster_counter.sv | 41 ++++
 rtl/block_draw.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/stacker_pkg.sv
// Shared constants and draw-state encoding for the block-stacker datapath.
// Consumed by block_draw and by the raster counter it instantiates.
package stacker_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int BLOCK_SIZE = 4;
    localparam int MAX_BLOCKS = 7;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } draw_state_t;

endpackage

// File: rtl/raster_counter.sv
// Row-major 2-D pixel counter: px runs 0..width_m1, then py steps; last marks the final pixel.
// Extents are runtime inputs so the same counter can sweep a block row or the whole screen.
module raster_counter #(
    parameter int X_BITS = 5,
    parameter int Y_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [X_BITS-1:0] width_m1,
    input  logic [Y_BITS-1:0] height_m1,
    output logic [X_BITS-1:0] px,
    output logic [Y_BITS-1:0] py,
    output logic              last
);

    logic [X_BITS-1:0] px_reg;
    logic [Y_BITS-1:0] py_reg;
    logic              row_end;

    assign row_end = (px_reg == width_m1);
    assign last    = row_end && (py_reg == height_m1);
    assign px      = px_reg;
    assign py      = py_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            px_reg <= '0;
            py_reg <= '0;
        end else if (en) begin
            if (row_end) begin
                px_reg <= '0;
                py_reg <= (py_reg == height_m1) ? '0 : py_reg + 1'b1;
            end else begin
                px_reg <= px_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_draw.sv
// Rasterises a horizontal run of square blocks into one VGA pixel write per cycle.
// Optional BLOCK_DRAW_BORDER_EN paints each block's outer ring white (non-erase draws only).
module block_draw #(
    parameter int BLOCK_SIZE = stacker_pkg::BLOCK_SIZE,
    parameter int MAX_BLOCKS = stacker_pkg::MAX_BLOCKS,
    parameter int SCREEN_W   = stacker_pkg::SCREEN_W,
    parameter int SCREEN_H   = stacker_pkg::SCREEN_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic [2:0] colour_in,
    input  logic       erase,
    input  logic [2:0] num_blocks,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot
);
    import stacker_pkg::*;

    localparam int PX_W = $clog2(BLOCK_SIZE * MAX_BLOCKS);
    localparam int PY_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

    draw_state_t state_reg;
    logic [7:0]  x_base_reg;
    logic [6:0]  y_base_reg;
    logic [2:0]  blocks_reg;
    logic [2:0]  colour_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        plot_reg;
    logic [7:0]  vga_x_reg;
    logic [6:0]  vga_y_reg;
    logic [2:0]  vga_colour_reg;
`ifdef BLOCK_DRAW_BORDER_EN
    logic        erase_reg;
`endif

    logic [PX_W-1:0] px;
    logic [PY_W-1:0] py;
    logic [PX_W-1:0] width_m1;
    logic [PY_W-1:0] height_m1;
    logic            last_pixel;
    logic            cnt_clear;
    logic            cnt_en;
    logic [2:0]      sat_blocks;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;
    logic            on_screen;
    logic [2:0]      pixel_colour;

    // Sums are one bit wider than the VGA coordinates so off-screen pixels clip instead of wrapping.
    always_comb begin
        width_m1   = PX_W'(32'(blocks_reg) * BLOCK_SIZE - 1);
        height_m1  = PY_W'(BLOCK_SIZE - 1);
        cnt_clear  = (state_reg == IDLE) && start;
        cnt_en     = (state_reg == DRAW);
        sat_blocks = (32'(num_blocks) > MAX_BLOCKS) ? 3'(MAX_BLOCKS) : num_blocks;
        sum_x      = {1'b0, x_base_reg} + 9'(px);
        sum_y      = {1'b0, y_base_reg} + 8'(py);
        on_screen  = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
        pixel_colour = colour_reg;
`ifdef BLOCK_DRAW_BORDER_EN
        if (!erase_reg && ((px[PY_W-1:0] == '0) || (px[PY_W-1:0] == height_m1) ||
                           (py == '0) || (py == height_m1)))
            pixel_colour = COLOUR_WHITE;
`endif
    end

    raster_counter #(
        .X_BITS(PX_W),
        .Y_BITS(PY_W)
    ) u_raster (
        .clk      (clk),
        .reset    (reset),
        .clear    (cnt_clear),
        .en       (cnt_en),
        .width_m1 (width_m1),
        .height_m1(height_m1),
        .px       (px),
        .py       (py),
        .last     (last_pixel)
    );

    // busy/done follow the state one edge late so they line up with the registered pixel stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            x_base_reg     <= '0;
            y_base_reg     <= '0;
            blocks_reg     <= '0;
            colour_reg     <= COLOUR_BLACK;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            plot_reg       <= 1'b0;
            vga_x_reg      <= '0;
            vga_y_reg      <= '0;
            vga_colour_reg <= COLOUR_BLACK;
`ifdef BLOCK_DRAW_BORDER_EN
            erase_reg      <= 1'b0;
`endif
        end else begin
            busy_reg <= (state_reg != IDLE);
            done_reg <= (state_reg == DONE);
            plot_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_base_reg <= x_in;
                        y_base_reg <= y_in;
                        blocks_reg <= sat_blocks;
                        colour_reg <= erase ? COLOUR_BLACK : colour_in;
`ifdef BLOCK_DRAW_BORDER_EN
                        erase_reg  <= erase;
`endif
                        state_reg  <= (sat_blocks == 3'd0) ? DONE : DRAW;
                    end
                end
                DRAW: begin
                    vga_x_reg      <= sum_x[7:0];
                    vga_y_reg      <= sum_y[6:0];
                    vga_colour_reg <= pixel_colour;
                    plot_reg       <= on_screen;
                    if (last_pixel)
                        state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign plot       = plot_reg;
    assign vga_x      = vga_x_reg;
    assign vga_y      = vga_y_reg;
    assign vga_colour = vga_colour_reg;

endmodule
